// File: rtl/regfile_pkg.sv
// Shared constants and packed-port slicing helper for the multi-port register file.
`ifndef RF_PSEL
`define RF_PSEL(p, w) ((p) * (w)) +: (w)
`endif

package regfile_pkg;

  localparam int RF_WIDTH    = 32;
  localparam int RF_DEPTH    = 32;
  localparam int RF_RD_PORTS = 2;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: write-through bypass priority, zero-register override, busy masking.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] stored_data_i,
  input  logic             stored_busy_i,
  input  logic             w0_en_i,
  input  logic [AW-1:0]    w0_addr_i,
  input  logic [WIDTH-1:0] w0_data_i,
  input  logic             w1_en_i,
  input  logic [AW-1:0]    w1_addr_i,
  input  logic [WIDTH-1:0] w1_data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);

  logic w0_hit;
  logic w1_hit;

  assign w0_hit = w0_en_i && (w0_addr_i == addr_i);
  assign w1_hit = w1_en_i && (w1_addr_i == addr_i);

  // Select stored value, forward same-cycle writes (W0 first), force r0 to zero/idle.
  always_comb begin
    data_o = stored_data_i;
    busy_o = stored_busy_i;
    if (BYPASS != 0) begin
      if (w0_hit) begin
        data_o = w0_data_i;
      end else if (w1_hit) begin
        data_o = w1_data_i;
      end
      if (w1_hit) begin
        busy_o = 1'b0;
      end
    end
    if ((ZERO_REG != 0) && (addr_i == '0)) begin
      data_o = '0;
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, busy scoreboard and sticky WAW flag;
// read muxing lives in regfile_rd_port, one instance per read port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = RF_WIDTH,
  parameter int  DEPTH    = RF_DEPTH,
  parameter int  RD_PORTS = RF_RD_PORTS,
  parameter int  BYPASS   = 1,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [RD_PORTS*AW-1:0]    rd_addr,
  output logic [RD_PORTS*WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]       rd_busy,
  input  logic                      w0_en,
  input  logic [AW-1:0]             w0_addr,
  input  logic [WIDTH-1:0]          w0_data,
  input  logic                      w1_en,
  input  logic [AW-1:0]             w1_addr,
  input  logic [WIDTH-1:0]          w1_data,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_addr,
  output logic                      waw_err
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             waw_q;
  logic             waw_d;

  logic w0_we;
  logic w1_we;
  logic rsv_we;

  // Requests aimed at a hardwired zero register are dropped before reaching state.
  assign w0_we  = w0_en  && !((ZERO_REG != 0) && (w0_addr  == '0));
  assign w1_we  = w1_en  && !((ZERO_REG != 0) && (w1_addr  == '0));
  assign rsv_we = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Next state: W1 applied before W0 so W0 wins a collision; reserve applied after
  // the W1 clear so a same-cycle set beats the clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    waw_d  = waw_q;
    if (w1_we) begin
      regs_d[w1_addr] = w1_data;
      busy_d[w1_addr] = 1'b0;
    end
    if (w0_we) begin
      regs_d[w0_addr] = w0_data;
    end
    if (rsv_we) begin
      if (busy_q[rsv_addr] && !(w1_en && (w1_addr == rsv_addr))) begin
        waw_d = 1'b1;
      end
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      waw_q  <= waw_d;
    end
  end

  assign waw_err = waw_q;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[`RF_PSEL(p, AW)];

    regfile_rd_port #(
      .WIDTH   (WIDTH),
      .AW      (AW),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .addr_i       (addr),
      .stored_data_i(regs_q[addr]),
      .stored_busy_i(busy_q[addr]),
      .w0_en_i      (w0_en),
      .w0_addr_i    (w0_addr),
      .w0_data_i    (w0_data),
      .w1_en_i      (w1_en),
      .w1_addr_i    (w1_addr),
      .w1_data_i    (w1_data),
      .data_o       (rd_data[`RF_PSEL(p, WIDTH)]),
      .busy_o       (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass instances share stimulus and a
// behavioural model; a 16x64, 4-port instance gets directed checks.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;

  // shared stimulus for instances A (BYPASS=1) and B (BYPASS=0)
  logic [9:0]  rd_addr;
  logic        w0_en, w1_en, rsv_en;
  logic [4:0]  w0_addr, w1_addr, rsv_addr;
  logic [31:0] w0_data, w1_data;
  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_busy, b_rd_busy;
  logic        a_waw, b_waw;

  // instance C (DEPTH=16, WIDTH=64, RD_PORTS=4)
  logic [15:0]  c_rd_addr;
  logic [255:0] c_rd_data;
  logic [3:0]   c_rd_busy;
  logic         c_w0_en, c_w1_en, c_rsv_en;
  logic [3:0]   c_w0_addr, c_w1_addr, c_rsv_addr;
  logic [63:0]  c_w0_data, c_w1_data;
  logic         c_waw;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_waw;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .RD_PORTS(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .waw_err(a_waw)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(32), .RD_PORTS(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .waw_err(b_waw)
  );

  regfile_mp #(.WIDTH(64), .DEPTH(16), .RD_PORTS(4), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clk(clk), .reset(reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .w0_en(c_w0_en), .w0_addr(c_w0_addr), .w0_data(c_w0_data),
    .w1_en(c_w1_en), .w1_addr(c_w1_addr), .w1_data(c_w1_data),
    .rsv_en(c_rsv_en), .rsv_addr(c_rsv_addr), .waw_err(c_waw)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
    m_waw  = 1'b0;
  endtask

  // Architectural effect of one clock edge on the model.
  task automatic model_edge();
    if (rsv_en && rsv_addr != 5'd0 && m_busy[rsv_addr] && !(w1_en && w1_addr == rsv_addr))
      m_waw = 1'b1;
    if (w1_en && w1_addr != 5'd0) begin
      m_regs[w1_addr] = w1_data;
      m_busy[w1_addr] = 1'b0;
    end
    if (w0_en && w0_addr != 5'd0) m_regs[w0_addr] = w0_data;
    if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && w0_en && w0_addr == a) return w0_data;
    if (byp && w1_en && w1_addr == a) return w1_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && w1_en && w1_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_reads();
    logic [4:0] a;
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      chk($sformatf("A_rd_data[%0d] r%0d", p, a), {32'd0, a_rd_data[p*32 +: 32]}, {32'd0, exp_data(a, 1'b1)});
      chk($sformatf("B_rd_data[%0d] r%0d", p, a), {32'd0, b_rd_data[p*32 +: 32]}, {32'd0, exp_data(a, 1'b0)});
      chk($sformatf("A_rd_busy[%0d] r%0d", p, a), {63'd0, a_rd_busy[p]}, {63'd0, exp_busy(a, 1'b1)});
      chk($sformatf("B_rd_busy[%0d] r%0d", p, a), {63'd0, b_rd_busy[p]}, {63'd0, exp_busy(a, 1'b0)});
    end
    chk("A_waw_err", {63'd0, a_waw}, {63'd0, m_waw});
    chk("B_waw_err", {63'd0, b_waw}, {63'd0, m_waw});
  endtask

  task automatic settle();
    #3;
    check_reads();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic idle();
    w0_en = 1'b0; w1_en = 1'b0; rsv_en = 1'b0;
    w0_addr = '0; w1_addr = '0; rsv_addr = '0;
    w0_data = '0; w1_data = '0;
  endtask

  task automatic c_idle();
    c_w0_en = 1'b0; c_w1_en = 1'b0; c_rsv_en = 1'b0;
    c_w0_addr = '0; c_w1_addr = '0; c_rsv_addr = '0;
    c_w0_data = '0; c_w1_data = '0;
  endtask

  task automatic rand_cycle(input int amax);
    w0_en    = 1'($urandom_range(0, 1));
    w0_addr  = 5'($urandom_range(0, amax));
    w0_data  = $urandom;
    w1_en    = 1'($urandom_range(0, 1));
    w1_addr  = 5'($urandom_range(0, amax));
    w1_data  = $urandom;
    rsv_en   = ($urandom_range(0, 3) == 0);
    rsv_addr = 5'($urandom_range(0, amax));
    rd_addr  = {5'($urandom_range(0, amax)), 5'($urandom_range(0, amax))};
    settle();
    tick();
  endtask

  // Assert reset (with arbitrary state present) and sweep every address while held.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    model_clear();
    #1;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(31 - a)};
      #1;
      check_reads();
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    c_idle();
    rd_addr = '0;
    c_rd_addr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // arbitrary traffic, then reset must wipe it
    for (int i = 0; i < 30; i++) rand_cycle(31);
    do_reset();
    chk("reset_waw", {63'd0, a_waw}, 64'd0);

    // write to r0 is dropped, bypass included
    w0_en = 1'b1; w0_addr = 5'd0; w0_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd0};
    settle();
    chk("r0_bypass", {32'd0, a_rd_data[31:0]}, 64'd0);
    tick();
    idle();
    settle();
    chk("r0_stored", {32'd0, a_rd_data[31:0]}, 64'd0);
    tick();

    // same-cycle bypass on port 1
    w0_en = 1'b1; w0_addr = 5'd5; w0_data = 32'h12345678; rd_addr = {5'd5, 5'd0};
    settle();
    chk("bypass_A_same", {32'd0, a_rd_data[63:32]}, 64'h12345678);
    chk("bypass_B_old", {32'd0, b_rd_data[63:32]}, 64'h0);
    tick();
    idle();
    settle();
    chk("bypass_B_next", {32'd0, b_rd_data[63:32]}, 64'h12345678);
    tick();

    // W0/W1 collision: W0 data wins
    w0_en = 1'b1; w0_addr = 5'd7; w0_data = 32'h1;
    w1_en = 1'b1; w1_addr = 5'd7; w1_data = 32'h2;
    rd_addr = {5'd0, 5'd7};
    settle();
    chk("collide_bypass", {32'd0, a_rd_data[31:0]}, 64'h1);
    tick();
    idle();
    settle();
    chk("collide_stored_A", {32'd0, a_rd_data[31:0]}, 64'h1);
    chk("collide_stored_B", {32'd0, b_rd_data[31:0]}, 64'h1);
    tick();

    // scoreboard reserve and W1 clear
    rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr = {5'd0, 5'd9};
    settle();
    chk("rsv_not_yet", {63'd0, a_rd_busy[0]}, 64'd0);
    tick();
    idle();
    settle();
    chk("rsv_busy_A", {63'd0, a_rd_busy[0]}, 64'd1);
    chk("rsv_busy_B", {63'd0, b_rd_busy[0]}, 64'd1);
    w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'hCAFE;
    settle();
    chk("w1clr_busy_A", {63'd0, a_rd_busy[0]}, 64'd0);
    chk("w1clr_data_A", {32'd0, a_rd_data[31:0]}, 64'hCAFE);
    chk("w1clr_busy_B", {63'd0, b_rd_busy[0]}, 64'd1);
    tick();
    idle();
    settle();
    chk("w1clr_after_B", {63'd0, b_rd_busy[0]}, 64'd0);
    tick();

    // set beats clear, then true WAW
    rsv_en = 1'b1; rsv_addr = 5'd9;
    settle();
    tick();
    w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'h55;
    settle();
    tick();
    idle();
    settle();
    chk("setwins_busy", {63'd0, a_rd_busy[0]}, 64'd1);
    chk("setwins_waw", {63'd0, a_waw}, 64'd0);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    settle();
    tick();
    idle();
    settle();
    chk("waw_set", {63'd0, a_waw}, 64'd1);
    tick();

    // randomized traffic on a narrow address window to force collisions
    for (int i = 0; i < 300; i++) rand_cycle(7);
    for (int i = 0; i < 100; i++) rand_cycle(31);
    idle();
    settle();
    chk("waw_sticky", {63'd0, a_waw}, 64'd1);
    do_reset();
    settle();
    chk("waw_cleared", {63'd0, a_waw}, 64'd0);

    // wide / deep / 4-port instance
    begin
      logic [63:0] vals [4];
      logic [3:0]  adrs [4];
      vals[0] = 64'h0123456789ABCDEF; adrs[0] = 4'd1;
      vals[1] = 64'hFEDCBA9876543210; adrs[1] = 4'd6;
      vals[2] = 64'hA5A5A5A55A5A5A5A; adrs[2] = 4'd11;
      vals[3] = 64'h8000000000000001; adrs[3] = 4'd15;
      for (int i = 0; i < 4; i++) begin
        c_w0_en = 1'b1; c_w0_addr = adrs[i]; c_w0_data = vals[i];
        @(posedge clk);
        #1;
      end
      c_idle();
      c_rd_addr = {adrs[0], adrs[1], adrs[2], adrs[3]};
      #3;
      for (int p = 0; p < 4; p++)
        chk($sformatf("C_port%0d", p), c_rd_data[p*64 +: 64], vals[3 - p]);
      c_rsv_en = 1'b1; c_rsv_addr = 4'd11;
      @(posedge clk);
      #1;
      c_idle();
      c_rd_addr = {4'd0, 4'd11, 4'd11, 4'd0};
      #3;
      chk("C_busy", {60'd0, c_rd_busy}, 64'b0110);
      chk("C_r0", c_rd_data[63:0], 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with write-through bypass and a per-register busy scoreboard for the enhanced MIPS datapath. It replaces the fixed 32x32, two-read/one-write file. It serves the decode stage: up to RD_PORTS asynchronous operand reads, an ALU write port (W0) and a long-latency write port (W1, for loads and multiply/divide). Registers awaiting a long-latency result are reserved, and the busy bit of each read port is reported so hazard logic can stall.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers (power of two, >=2); AW = $clog2(DEPTH)
- RD_PORTS, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- rd_addr  in  RD_PORTS*AW  packed read addresses, port p at [p*AW +: AW]
- rd_data  out  RD_PORTS*WIDTH  packed read data, combinational
- rd_busy  out  RD_PORTS  busy bit of addressed register, after this cycle's W1 clear
- w0_en, w0_addr, w0_data  in  1, AW, WIDTH  ALU write port
- w1_en, w1_addr, w1_data  in  1, AW, WIDTH  long-latency write port; clears busy
- rsv_en, rsv_addr  in  1, AW  reserve register (set busy) at next edge
- waw_err  out  1  sticky: reservation issued on an already-busy register

## Operation
- Reset: all DEPTH registers = 0, all busy bits = 0, waw_err = 0. Asserting reset mid-operation clears all state immediately. Write and reserve inputs are ignored while reset is high.
- Write: on the rising edge, if wN_en is set, regs[wN_addr] <= wN_data.
- Same-address collision of W0 and W1: W0 data is stored, and the W1 busy-clear still takes effect.
- ZERO_REG=1: writes and reservations to address 0 are dropped. Reads of address 0 return 0 and rd_busy = 0, regardless of BYPASS.
- Read, BYPASS=1: if w0_en and w0_addr==rd_addr, return w0_data. Otherwise, if w1_en and w1_addr==rd_addr, return w1_data. Otherwise return regs[rd_addr].
- Read, BYPASS=0: always return regs[rd_addr]; the new value is visible the cycle after the edge.
- Scoreboard: rsv_en sets busy[rsv_addr]; w1_en clears busy[w1_addr]. If both target the same address in the same cycle, the set wins (busy stays 1). A W0 write does not touch busy.
- rd_busy[p] = busy[rd_addr_p] & ~(w1_en & w1_addr==rd_addr_p). Under BYPASS=0 it is busy[rd_addr_p] only.
- waw_err: set on an edge where rsv_en=1, the address is not the zero register, busy[rsv_addr]=1, and there is no same-cycle W1 clear of that address. It clears only on reset.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

## Timing
- Read: zero-cycle combinational path from rd_addr, write ports and regs to rd_data.
- Write: stored at the edge and visible in the same cycle through bypass, or in the next cycle from storage.
- Reserve: busy visible on rd_busy in the cycle after the rsv_en edge.
- W1 clear: visible combinationally in its own cycle (BYPASS=1) or after the edge (BYPASS=0).
- No handshake and no backpressure; every enabled request completes in one edge.

## Structure
- Shared package regfile_pkg holds:
  - the default parameter constants (RF_WIDTH=32, RF_DEPTH=32, RF_RD_PORTS=2);
  - the port-select macro for packed slicing.
- One sub-module, regfile_rd_port, holds the per-port mux: bypass priority, zero-register override and busy masking. It is instantiated RD_PORTS times in a generate loop.
- Storage and the scoreboard stay in the top level.

## Test plan
- Reset and zero register: assert reset after arbitrary writes, then read all addresses → every rd_data = 0 and rd_busy = 0. Write 0xDEADBEEF to r0 → a read of r0 returns 0.
- Bypass: W0 writes r5=0x12345678 while port 1 reads r5 → rd_data returns 0x12345678 in the same cycle. With BYPASS=0 the first read returns the old value 0 and the next cycle returns 0x12345678.
- Collision: W0 r7=0x1, W1 r7=0x2 in the same cycle → stored value and bypass value are both 0x1.
- Scoreboard: rsv r9 → rd_busy=1 from the next cycle. W1 r9=0xCAFE → rd_busy=0 in the same cycle (BYPASS=1) and data = 0xCAFE.
- Set beats clear: rsv r9 with a same-cycle W1 clear of r9 → busy remains 1 and waw_err remains 0. A second rsv r9 with no clear → waw_err=1, holding until reset.
- Parameters: DEPTH=16, WIDTH=64, RD_PORTS=4. All four ports read distinct registers → each returns its own 64-bit value.
